// File: rtl/matmul_engine.sv
// -----------------------------------------------------------------------------
// matmul_engine
//   Computes C = A x B for 2x2 unsigned 8-bit matrices on a 2x2
//   output-stationary systolic array of MAC cells. The array is fed with
//   skewed operands and the four 16-bit results are streamed out bytewise.
//   Operands are snapshotted in LOAD, so the source memory may change while a
//   multiply is in flight.
//
// Parameters
//   SATURATE      1: results clamp to 16'hFFFF on overflow, 0: wrap mod 2^16
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst_n         synchronous active-low reset
//   start         request a multiply (sampled only in IDLE)
//   weight0..3    matrix A row-major: a00, a01, a10, a11
//   input0..3     matrix B row-major: b00, b01, b10, b11
//   busy          high in every state except IDLE
//   out_data      current result byte (0 outside DRAIN)
//   out_valid     out_data holds a valid byte
//   out_ready     consumer ready for the byte
//   done          one-cycle pulse after the last byte is accepted
//
// Output handshake: out_valid stays high for the whole of DRAIN and out_data
// shows byte idx_q. A byte transfers on a rising edge where out_valid and
// out_ready are both high; until then out_data holds, however long the stall.
// -----------------------------------------------------------------------------
module matmul_engine #(
  parameter bit SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] weight0,
  input  logic [7:0] weight1,
  input  logic [7:0] weight2,
  input  logic [7:0] weight3,
  input  logic [7:0] input0,
  input  logic [7:0] input1,
  input  logic [7:0] input2,
  input  logic [7:0] input3,
  output logic       busy,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  step_q;
  logic [2:0]  idx_q;
  logic [7:0]  a_q   [4];
  logic [7:0]  b_q   [4];
  logic [16:0] acc_q [4];
  logic [15:0] prod  [4];
  logic [15:0] res;
  logic        accept;

  // Saturating or wrapping conversion of a 17-bit accumulator to 16 bits.
  function automatic logic [15:0] to_out(input logic [16:0] v);
    if (SATURATE && v[16]) to_out = 16'hFFFF;
    else                   to_out = v[15:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Systolic feed. PE(r,c) sees operand pair k at step t = r + c + k, which is
  // the diagonal wavefront a skewed systolic feed produces: PE00 works at
  // steps 0-1, PE01/PE10 at 1-2 and PE11 at 2-3. Outside its window a PE adds 0.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < 2; r++) begin : g_row
    for (genvar c = 0; c < 2; c++) begin : g_col
      localparam logic [1:0] T0 = 2'(r + c);
      localparam logic [1:0] T1 = 2'(r + c + 1);
      logic [15:0] pe_prod;

      always_comb begin
        pe_prod = '0;
        if (state_q == ST_COMPUTE) begin
          if (step_q == T0)
            pe_prod = {8'd0, a_q[r*2]} * {8'd0, b_q[c]};
          else if (step_q == T1)
            pe_prod = {8'd0, a_q[r*2+1]} * {8'd0, b_q[2+c]};
        end
      end

      assign prod[r*2+c] = pe_prod;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD:    state_d = ST_COMPUTE;
      ST_COMPUTE: if (step_q == 2'd3) state_d = ST_DRAIN;
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && idx_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = out_valid && out_ready;

  // Byte idx_q: idx_q[2:1] selects the result, idx_q[0] the half (low first).
  always_comb begin
    res      = to_out(acc_q[idx_q[2:1]]);
    out_data = '0;
    if (state_q == ST_DRAIN) out_data = idx_q[0] ? res[15:8] : res[7:0];
  end

  // ---------------------------------------------------------------------------
  // State register, snapshot, accumulators and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      idx_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[2'(i)]   <= '0;
        b_q[2'(i)]   <= '0;
        acc_q[2'(i)] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_LOAD: begin
          a_q[0] <= weight0;
          a_q[1] <= weight1;
          a_q[2] <= weight2;
          a_q[3] <= weight3;
          b_q[0] <= input0;
          b_q[1] <= input1;
          b_q[2] <= input2;
          b_q[3] <= input3;
          for (int i = 0; i < 4; i++) acc_q[2'(i)] <= '0;
          step_q <= '0;
          idx_q  <= '0;
        end
        ST_COMPUTE: begin
          // 17-bit accumulators hold 2*255*255 without overflow.
          for (int i = 0; i < 4; i++)
            acc_q[2'(i)] <= acc_q[2'(i)] + {1'b0, prod[2'(i)]};
          step_q <= step_q + 2'd1;
        end
        ST_DRAIN: if (accept) idx_q <= idx_q + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// -----------------------------------------------------------------------------
// tb_matmul_engine
//   Self-checking bench for matmul_engine. Two instances share all inputs:
//   dut (SATURATE=1) and dut_w (SATURATE=0). Expected bytes come from a plain
//   arithmetic model of C = A x B and are queued per instance.
// -----------------------------------------------------------------------------
module tb_matmul_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic       out_ready;
  logic       busy, out_valid, done;
  logic [7:0] out_data;
  logic       busy_w, out_valid_w, done_w;
  logic [7:0] out_data_w;

  matmul_engine #(.SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .input0(input0), .input1(input1), .input2(input2), .input3(input3),
    .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  matmul_engine #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .input0(input0), .input1(input1), .input2(input2), .input3(input3),
    .busy(busy_w), .out_data(out_data_w), .out_valid(out_valid_w),
    .out_ready(out_ready), .done(done_w)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];     // expected bytes, saturating instance
  logic [7:0] exp_w_q[$];   // expected bytes, wrapping instance
  logic [7:0] op_a[4];
  logic [7:0] op_b[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: C[r][c] = sum_k A[r][k] * B[k][c], then clamp or wrap.
  task automatic push_expected();
    int sum;
    int sat;
    int wrp;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        sum = 0;
        for (int k = 0; k < 2; k++) sum += int'(op_a[r*2+k]) * int'(op_b[k*2+c]);
        sat = (sum > 65535) ? 65535 : sum;
        wrp = sum % 65536;
        exp_q.push_back(8'(sat));
        exp_q.push_back(8'(sat / 256));
        exp_w_q.push_back(8'(wrp));
        exp_w_q.push_back(8'(wrp / 256));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ops();
    weight0 = op_a[0]; weight1 = op_a[1]; weight2 = op_a[2]; weight3 = op_a[3];
    input0  = op_b[0]; input1  = op_b[1]; input2  = op_b[2]; input3  = op_b[3];
  endtask

  task automatic zero_pins();
    weight0 = '0; weight1 = '0; weight2 = '0; weight3 = '0;
    input0  = '0; input1  = '0; input2  = '0; input3  = '0;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      op_a[i] = a[31-8*i -: 8];
      op_b[i] = b[31-8*i -: 8];
    end
  endtask

  // One full multiply. ready_mode: 0 always ready, 1 pattern 1,0,0,...,
  // 2 random. noise: re-pulse start in COMPUTE and DRAIN and zero the
  // operand pins after LOAD; none of it may disturb the result.
  task automatic run_mult(input int ready_mode, input bit noise);
    int         lat;
    int         acc;
    int         cyc;
    int         dones;
    int         extra;
    bit         stalled;
    logic [7:0] held;
    logic [7:0] held_w;
    push_expected();
    drive_ops();
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);                      // edge E samples start
    #1 start = 1'b0;
    @(negedge clk);
    lat = 0;
    check("busy_after_start", busy, 1);
    while (!out_valid && lat < 20) begin
      if (noise && lat == 1) begin       // LOAD edge already passed
        start = 1'b1;
        zero_pins();
      end
      if (noise && lat == 2) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("first_valid_latency", lat, 5);

    acc = 0; cyc = 0; dones = 0; stalled = 1'b0; held = '0; held_w = '0;
    while (acc < 8 && cyc < 200) begin
      if (done) dones++;
      if (stalled) begin
        check("stall_hold", out_data, held);
        check("stall_hold_w", out_data_w, held_w);
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      start = noise && (acc == 3);
      if (out_valid && out_ready) begin
        check("byte_sat", out_data, exp_q.pop_front());
        check("byte_wrap", out_data_w, exp_w_q.pop_front());
        acc++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        held    = out_data;
        held_w  = out_data_w;
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("bytes_accepted", acc, 8);
    check("done_during_drain", dones, 0);
    exp_q.delete();
    exp_w_q.delete();
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    check("valid_in_done", out_valid, 0);
    @(negedge clk);
    check("done_low", done, 0);
    check("busy_idle", busy, 0);
    if (noise) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (busy || done) extra++;
      end
      check("no_queued_start", extra, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         got_valid;
    int         vstart[$];
    int         done_at[$];
    bit         prev_valid;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    zero_pins();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;

    // 1: basic multiply, always ready
    set_ops(32'h01020304, 32'h05060708);
    run_mult(0, 1'b0);

    // 2: all 255, saturation vs wrap
    set_ops(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mult(0, 1'b0);

    // 3: stalling consumer
    set_ops(32'h01020304, 32'h05060708);
    run_mult(1, 1'b0);

    // 4: stray starts and operand rewrite after LOAD
    set_ops(32'h01020304, 32'h05060708);
    run_mult(0, 1'b1);

    // 5: reset in COMPUTE step 2, then identity multiply
    set_ops(32'h01020304, 32'h05060708);
    drive_ops();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);           // after E+3: COMPUTE step 2
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_data", out_data, 0);
    got_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || busy || done) got_valid++;
    end
    check("no_partial_output", got_valid, 0);
    set_ops(32'h01000001, 32'h09080706);
    run_mult(0, 1'b0);

    // randomized operands and consumer
    for (int n = 0; n < 6; n++) begin
      ra = $urandom();
      rb = $urandom();
      if (n == 0) ra = 32'hFFFF00FF;
      set_ops(ra, rb);
      run_mult(2, 1'b0);
    end

    // 6: start held high for 30 cycles -> two back-to-back multiplies
    set_ops(32'h01000001, 32'h09080706);
    drive_ops();
    push_expected();
    push_expected();
    out_ready  = 1'b1;
    prev_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);                    // after edge E+i
      if (i == 29) start = 1'b0;
      if (out_valid) begin
        if (!prev_valid) vstart.push_back(i);
        if (exp_q.size() > 0) begin
          check("b2b_byte", out_data, exp_q.pop_front());
          check("b2b_byte_w", out_data_w, exp_w_q.pop_front());
        end else begin
          check("b2b_extra_byte", 1, 0);
        end
      end
      if (done) done_at.push_back(i);
      prev_valid = out_valid;
    end
    out_ready = 1'b0;
    check("b2b_bytes_left", exp_q.size(), 0);
    check("b2b_done_count", done_at.size(), 2);
    check("b2b_run_count", vstart.size(), 2);
    if (vstart.size() >= 2 && done_at.size() >= 1)
      check("b2b_restart_gap", vstart[1] - done_at[0], 7);
    else
      check("b2b_restart_seen", 0, 1);
    check("b2b_idle_end", busy, 0);
    exp_q.delete();
    exp_w_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
